// File: rtl/fifo_uart_tx_pkg.sv
// Shared 8N1 UART definitions for the FIFO-draining transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the 8-bit synchronous FIFO as seen by its consumer.
interface fifo_uart_tx_if #(parameter int DATA_W = 8);

   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_re;

   modport master (output fifo_re, input fifo_empty, input fifo_data);
   modport slave  (input fifo_re, output fifo_empty, output fifo_data);

endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: ticks on the last clock of every bit, held at zero while cleared.
module baud_tick_gen #(
   parameter  int CLKS_PER_BIT = 16,
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   output logic          tick_o,
   output logic [CW-1:0] cnt_o
);

   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear_i || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = !clear_i && (cnt_q == LAST);
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO one byte at a time and serialises each byte as a UART 8N1 frame.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fifo_uart_tx_if.master        fifo,
   input  logic                  enable,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_W);
   localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [IW-1:0]     idx_q;
   logic              re_q, tx_q, busy_q, done_q;
   logic              tick, baud_clr;
   logic [CW-1:0]     cnt;

   // Counter only runs while a frame is on the line, so START always sees a full bit.
   assign baud_clr = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(baud_clr),
      .tick_o (tick),
      .cnt_o  (cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         re_q    <= 1'b0;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         re_q   <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (enable && !fifo.fifo_empty) begin
               state_q <= FETCH;
               re_q    <= 1'b1;
               busy_q  <= 1'b1;
            end
            FETCH: state_q <= LOAD;
            LOAD: begin
               shift_q <= fifo.fifo_data;
               tx_q    <= START_BIT;
               state_q <= START;
            end
            START: if (tick) begin
               tx_q    <= shift_q[0];
               idx_q   <= '0;
               state_q <= DATA;
            end
            DATA: if (tick) begin
               if (idx_q == IW'(DATA_W - 1)) begin
                  tx_q    <= STOP_BIT;
                  state_q <= STOP;
               end else begin
                  // Present the next bit on the same edge that retires the current one.
                  tx_q    <= shift_q[1];
                  shift_q <= shift_q >> 1;
                  idx_q   <= idx_q + IW'(1);
               end
            end
            STOP: begin
               if (cnt == PRE_LAST) done_q <= 1'b1;
               if (tick) begin
                  if (enable && !fifo.fifo_empty) begin
                     state_q <= FETCH;
                     re_q    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fifo.fifo_re = re_q;
   assign tx           = tx_q;
   assign busy         = busy_q;
   assign tx_done      = done_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the 8-bit synchronous FIFO. Drains the FIFO one byte at a time while it is non-empty and serialises each byte onto a UART 8N1 line. Sits between the FIFO's read port (re, empty, data_out) and the board TX pin. Provides busy and per-byte done status to the host.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit period; must be at least 2.
DATA_W, 8, byte width; matches the FIFO data width and is fixed at 8 for 8N1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO data_out; valid on the cycle after re is sampled high.
fifo_re  output  1  FIFO read enable; single-cycle pulse, one per byte.
tx  output  1  serial line; idles high.
busy  output  1  high from FETCH through the end of STOP.
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.
enable  input  1  host gate; when low, no new fetch starts and an in-flight byte completes.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, fifo_re=0, tx=1, busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: if enable=1 and fifo_empty=0, go to FETCH. Otherwise stay in IDLE with tx=1.
- FETCH: fifo_re=1 for exactly this cycle. Next state is LOAD.
- LOAD: capture fifo_data into the shift register. Next state is START. The FIFO read latency is 1 cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit. After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done pulses on the final cycle.
- After STOP: if enable=1 and fifo_empty=0, go straight to FETCH (back-to-back bytes, 2 idle-high cycles between stop and next start from FETCH/LOAD). Otherwise go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles from START entry to STOP exit. Latency from IDLE with non-empty FIFO to the tx falling edge is 3 cycles (FETCH, LOAD, then the START register edge).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is $clog2(CLKS_PER_BIT).
- tx, fifo_re and tx_done are registered outputs, with no combinational path from inputs.
- fifo_empty is sampled only in IDLE and at STOP exit. A read is never issued while fifo_empty=1, so a read-on-empty is impossible by construction.
- Writer activity during a frame has no effect on the frame in progress; the new byte is picked up at STOP exit.
- enable deasserted mid-frame: the current frame completes, then the FSM returns to IDLE.
- rst_n asserted mid-frame: the frame is aborted and tx goes high immediately (async). No FIFO read is issued after release until fifo_empty=0 is seen in IDLE.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package uart_pkg: state enum (IDLE..STOP), the 8N1 constants START_BIT=0, STOP_BIT=1, FRAME_BITS=10, and an idle-level constant.
- One sub-module, baud_tick_gen: a CLKS_PER_BIT counter with a clear input and a one-cycle tick output. The FSM advances bits on tick.

Test Plan:
- Reset: hold rst_n=0 with fifo_empty=0 -> tx=1, fifo_re=0, busy=0, tx_done=0 throughout; no read issued.
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5, enable=1 -> exactly one fifo_re pulse; tx=0 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then tx=1 for 4 cycles; one tx_done pulse; FSM returns to IDLE once fifo_empty=1.
- Back-to-back bytes: FIFO holds 0x00,0xFF,0x3C -> 3 fifo_re pulses and 3 tx_done pulses; each frame is 40 cycles; gap between frames is 2 cycles of tx=1; decoded bytes match in order.
- Full drain: FIFO filled with 16 bytes from {$random}%8 -> 16 reads, 16 frames with correct decoded values; fifo_re is never high while fifo_empty=1.
- enable dropped mid-frame after bit 3: the frame completes intact; no further fifo_re while enable=0; raising enable resumes with the next byte.
- Reset during DATA bit 5: tx goes to 1 asynchronously and busy goes to 0; after release, the next byte is sent as a complete, correct frame.
